// File: rtl/seq_multiplier_if.sv
// Handshake and operand/result bundle for seq_multiplier.
// The master issues start and operands; the slave returns busy, done and product.
interface seq_multiplier_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, is_signed, op_a, op_b,
    input  busy, done, product
  );

  modport slave (
    input  start, is_signed, op_a, op_b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, signed or unsigned.
// Operands are reduced to magnitudes on accept; the sign is reapplied when the product is written.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  seq_multiplier_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam int PW    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    product_q, product_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             a_neg_s, b_neg_s, neg_s;
  logic [WIDTH-1:0] mag_a_s, mag_b_s;
  logic [PW-1:0]    addend_s;

  // The magnitude of the most negative value still fits WIDTH bits unsigned.
  assign a_neg_s  = bus.is_signed & bus.op_a[WIDTH-1];
  assign b_neg_s  = bus.is_signed & bus.op_b[WIDTH-1];
  assign neg_s    = a_neg_s ^ b_neg_s;
  assign mag_a_s  = a_neg_s ? (~bus.op_a + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.op_a;
  assign mag_b_s  = b_neg_s ? (~bus.op_b + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.op_b;
  assign addend_s = {{WIDTH{1'b0}}, mcand_q} << cnt_q;

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    product_d = product_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = RUN;
          busy_d   = 1'b1;
          mcand_d  = mag_a_s;
          mplier_d = mag_b_s;
          neg_d    = neg_s;
          acc_d    = {PW{1'b0}};
          cnt_d    = {CNT_W{1'b0}};
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        if (mplier_q[cnt_q]) begin
          acc_d = acc_q + addend_s;
        end else begin
          acc_d = acc_q;
        end
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      DONE: begin
        product_d = neg_q ? (~acc_q + {{(PW-1){1'b0}}, 1'b1}) : acc_q;
        done_d    = 1'b1;
        // A start seen here chains straight into the next operation.
        if (bus.start) begin
          state_d  = RUN;
          busy_d   = 1'b1;
          mcand_d  = mag_a_s;
          mplier_d = mag_b_s;
          neg_d    = neg_s;
          acc_d    = {PW{1'b0}};
          cnt_d    = {CNT_W{1'b0}};
        end else begin
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      mcand_q   <= {WIDTH{1'b0}};
      mplier_q  <= {WIDTH{1'b0}};
      acc_q     <= {PW{1'b0}};
      product_q <= {PW{1'b0}};
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      neg_q     <= neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=8 and WIDTH=32.
// Expected products are hand-computed constants in a vector table plus multi-cycle sequences.
module tb_seq_multiplier;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  seq_multiplier_if #(.WIDTH(8))  b8 ();
  seq_multiplier_if #(.WIDTH(32)) b32 ();

  seq_multiplier #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8));
  seq_multiplier #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input bit wide, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] prod, output int lat, output int bcnt);
    @(negedge clk);
    if (wide) begin
      b32.start = 1'b1; b32.is_signed = sgn; b32.op_a = a; b32.op_b = b;
    end else begin
      b8.start = 1'b1; b8.is_signed = sgn; b8.op_a = a[7:0]; b8.op_b = b[7:0];
    end
    @(posedge clk);
    lat  = -1;
    bcnt = 0;
    prod = 64'h0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 0) begin
        b8.start  = 1'b0;
        b32.start = 1'b0;
      end
      if (wide ? b32.busy : b8.busy) bcnt++;
      if (wide ? b32.done : b8.done) begin
        lat  = k;
        prod = wide ? b32.product : {48'h0, b8.product};
        break;
      end
    end
  endtask

  initial begin
    logic [63:0] prod;
    logic [15:0] last_prod;
    int          lat, bcnt, dones, first_k, stable_bad;
    int          done_k [3];
    logic [15:0] done_p [3];

    vecs[0]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[1]  = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};
    vecs[2]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[3]  = '{1'b1, 8'h80, 8'h01, 16'hFF80};
    vecs[4]  = '{1'b0, 8'h07, 8'h06, 16'h002A};
    vecs[5]  = '{1'b1, 8'h7F, 8'h80, 16'hC080};
    vecs[6]  = '{1'b0, 8'h00, 8'hFF, 16'h0000};
    vecs[7]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[8]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
    vecs[9]  = '{1'b1, 8'h00, 8'h80, 16'h0000};
    vecs[10] = '{1'b0, 8'h0F, 8'h10, 16'h00F0};
    vecs[11] = '{1'b1, 8'h05, 8'hFB, 16'hFFE7};

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    b8.start  = 1'b0; b8.is_signed  = 1'b0; b8.op_a  = 8'h00;  b8.op_b  = 8'h00;
    b32.start = 1'b0; b32.is_signed = 1'b0; b32.op_a = 32'h0;  b32.op_b = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'h0, b8.busy}, 64'h0);
    check("reset_done", {63'h0, b8.done}, 64'h0);
    check("reset_product", {48'h0, b8.product}, 64'h0);
    check("reset_product32", b32.product, 64'h0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op(1'b0, vecs[i].sgn, {24'h0, vecs[i].a}, {24'h0, vecs[i].b}, prod, lat, bcnt);
      check($sformatf("vec%0d_product", i), prod, {48'h0, vecs[i].exp});
      check($sformatf("vec%0d_latency", i), lat, 9);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, 8);
    end

    run_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, prod, lat, bcnt);
    check("w32_product", prod, 64'hFFFFFFFE00000001);
    check("w32_latency", lat, 33);
    check("w32_busy_cycles", bcnt, 32);

    // start pulsed mid-RUN must be ignored
    @(negedge clk);
    b8.start = 1'b1; b8.is_signed = 1'b0; b8.op_a = 8'h03; b8.op_b = 8'h04;
    @(posedge clk);
    dones = 0; first_k = -1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (k == 0) b8.start = 1'b0;
      if (k == 3) begin b8.start = 1'b1; b8.op_a = 8'h05; b8.op_b = 8'h05; end
      if (k == 4) b8.start = 1'b0;
      if (b8.done) begin
        dones++;
        if (first_k < 0) first_k = k;
      end
    end
    check("ignore_done_count", dones, 1);
    check("ignore_done_latency", first_k, 9);
    check("ignore_product", {48'h0, b8.product}, 64'h000C);

    // start held high across three back-to-back operations
    @(negedge clk);
    b8.start = 1'b1; b8.is_signed = 1'b1; b8.op_a = 8'hFD; b8.op_b = 8'h05;
    @(posedge clk);
    dones = 0; stable_bad = 0; last_prod = 16'h0;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      if (k == 8)  begin b8.op_a = 8'h80; b8.op_b = 8'h80; end
      if (k == 17) begin b8.op_a = 8'h7F; b8.op_b = 8'h7F; end
      if (k == 26) b8.start = 1'b0;
      if (b8.done) begin
        if (dones < 3) begin
          done_k[dones] = k;
          done_p[dones] = b8.product;
        end
        dones++;
        last_prod = b8.product;
      end else if (dones > 0 && b8.product !== last_prod) begin
        stable_bad++;
      end
    end
    check("b2b_done_count", dones, 3);
    if (dones >= 3) begin
      check("b2b_done0_cycle", done_k[0], 9);
      check("b2b_done1_cycle", done_k[1], 18);
      check("b2b_done2_cycle", done_k[2], 27);
      check("b2b_product0", {48'h0, done_p[0]}, 64'hFFF1);
      check("b2b_product1", {48'h0, done_p[1]}, 64'h4000);
      check("b2b_product2", {48'h0, done_p[2]}, 64'h3F01);
    end
    check("b2b_product_stable", stable_bad, 0);

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    b8.start = 1'b1; b8.is_signed = 1'b0; b8.op_a = 8'h55; b8.op_b = 8'h33;
    @(posedge clk);
    @(negedge clk);
    b8.start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun_busy_before_reset", {63'h0, b8.busy}, 64'h1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_busy", {63'h0, b8.busy}, 64'h0);
    check("async_reset_done", {63'h0, b8.done}, 64'h0);
    check("async_reset_product", {48'h0, b8.product}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (b8.done) dones++;
    end
    check("post_reset_no_done", dones, 0);
    run_op(1'b0, 1'b0, 32'h7, 32'h6, prod, lat, bcnt);
    check("post_reset_product", prod, 64'h002A);
    check("post_reset_latency", lat, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
